aes_mixcol_iter: RTL and testbench
==================================

Name: aes_mixcol_iter

Overview:
- Iterative, parametrised MixColumns / InvMixColumns engine with a run-time mode select.
- Accepts one Nb-column AES state over a valid/ready handshake and transforms COLS columns per clock, in place, in an internal state register.
- Presents the result over a valid/ready output handshake with full backpressure.
- Serves as the area-scalable column-mixing stage for both the encrypt round datapath and the decrypt round datapath.
- Computes GF(2^8) products with xtime chains, not EXP/LN lookup tables.

Parameters:
- COLS, 1, columns processed per BUSY cycle; legal values are 1, 2 and 4; Nb % COLS must be 0, otherwise elaboration fails.
- Nb, taken from aes_const (4), number of state columns; not overridable per instance.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  in  1  State_in and mode are valid.
- in_ready  out  1  block can accept a state this cycle.
- mode  in  1  0 = MixColumns (02 03 01 01), 1 = InvMixColumns (0e 0b 0d 09); sampled at accept.
- State_in  in  8 x [0:4*Nb-1]  input state, column-major (byte 4*i+r = row r of column i).
- out_valid  out  1  State_out holds a completed result.
- out_ready  in  1  consumer takes the result this cycle.
- State_out  out  8 x [0:4*Nb-1]  transformed state, same byte ordering; driven directly from the state register.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (rst == 0 at a rising edge): state goes to IDLE, col_idx = 0, in_ready = 0 on the reset cycle, out_valid = 0, state register and State_out = all zero, mode_q = 0.
  - Reset in the middle of an operation abandons it; no partial result is ever flagged valid.
- in_ready = (fsm == IDLE) || (fsm == DONE && out_ready). This is combinational from fsm and out_ready.
- Accept occurs when in_valid && in_ready at a rising edge. On accept:
  - State_in is registered and mode is registered into mode_q.
  - col_idx is set to 0 and the FSM goes to BUSY.
- BUSY cycle behaviour:
  - Columns col_idx .. col_idx+COLS-1 are replaced by their transform under mode_q.
  - col_idx advances by COLS.
  - When the group just processed is the last one (col_idx + COLS == Nb), the FSM goes to DONE.
- DONE behaviour:
  - out_valid = 1.
  - State_out is held stable while out_ready == 0, for any number of cycles.
- Transfer from DONE:
  - out_valid && out_ready with no simultaneous accept: next state is IDLE.
  - out_valid && out_ready with a simultaneous accept (back-to-back): the new state is loaded and the FSM goes directly to BUSY. out_valid drops for the following cycle.
- Latency: out_valid rises Nb/COLS rising edges after the accepting edge, i.e. 4, 2 or 1 edges for COLS = 1, 2, 4.
- Throughput: one state per Nb/COLS + 1 cycles with out_ready held high.
- in_valid, mode and State_in are ignored in BUSY, and in DONE when out_ready == 0.
- Changing mode after accept has no effect on an operation in flight.
- Per-column arithmetic, with row bytes a0..a3:
  - Forward: o_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3).
  - Inverse: o_r = e*a_r ^ b*a_(r+1) ^ d*a_(r+2) ^ 9*a_(r+3).
  - Row indices are taken mod 4.
  - Field is GF(2^8) with reduction polynomial 0x11b.
  - xtime(x) = (x << 1) ^ (x[7] ? 8'h1b : 0).
  - All intermediates are 8 bits; no carries.
- Zero bytes need no special case: they produce 0 naturally. This differs from the log-table method, which does need one.

Decomposition:
- aes_const holds Nb.
- aes_wire (shared package) gains:
  - fsm enum mixcol_fsm_t {IDLE, BUSY, DONE}.
  - function xtime.
  - constants MIX_FWD = 1'b0 and MIX_INV = 1'b1.
- One combinational sub-module, aes_mixcol_unit:
  - Ports: 4-byte column in, mode in, 4-byte column out.
  - Instantiated COLS times in a generate loop.
  - Column selection by col_idx is done by a multiplexer in the parent module.

Test Plan:
- Forward single column, COLS=1: column db 13 53 45 in column 0, remaining columns f2 0a 22 5c / 01 01 01 01 / c6 c6 c6 c6, mode=0 -> State_out columns 8e 4d a1 bc / 9f dc 58 9d / 01 01 01 01 / c6 c6 c6 c6; out_valid exactly 4 edges after accept.
- Inverse round-trip, COLS=2: input 8e 4d a1 bc / 9f dc 58 9d / d5 d5 d7 d6 / 4d 7e bd f8, mode=1 -> db 13 53 45 / f2 0a 22 5c / d4 d4 d4 d5 / 2d 26 31 4c; latency 2 edges.
- COLS=4 latency and zero state: all-zero input in both modes -> all-zero output after 1 edge; a fresh accept in the same cycle as the DONE transfer is taken, and out_valid is low for exactly one cycle in between.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> State_out stable, in_ready=0; toggle in_valid and mode during this time -> no effect on the result; then out_ready=1 -> transfer, FSM returns to IDLE.
- Reset mid-BUSY: assert rst=0 after 2 BUSY edges -> next edge gives out_valid=0, State_out=0, IDLE; a new accept afterwards yields a correct result.
- Random regression: 1000 random states and modes per COLS setting, compared against a reference model; forward followed by inverse must return the original state.

Source files
------------

// File: rtl/aes_const.sv
// AES geometry constants shared across the round datapath.
package aes_const;
    localparam int Nb = 4;
endpackage

// File: rtl/aes_wire.sv
// Shared types and GF(2^8) helpers for the AES column-mixing stage.
package aes_wire;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mixcol_fsm_t;

    localparam logic MIX_FWD = 1'b0;
    localparam logic MIX_INV = 1'b1;

    // One AES column, element r is row r.
    typedef logic [0:3][7:0] col_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes_mixcol_unit.sv
// Combinational MixColumns / InvMixColumns of a single column, built from xtime chains.
module aes_mixcol_unit
    import aes_wire::*;
(
    input  col_t col_in,
    input  logic mode,
    output col_t col_out
);

    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            m2[i] = xtime(col_in[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
        end
    end

    // Row r combines bytes r, r+1, r+2, r+3 (mod 4) with the circulant coefficients.
    always_comb begin
        col_out = '0;
        for (int r = 0; r < 4; r++) begin
            logic [1:0] i0, i1, i2, i3;
            i0 = 2'(r);
            i1 = 2'(r + 1);
            i2 = 2'(r + 2);
            i3 = 2'(r + 3);
            if (mode == MIX_FWD) begin
                col_out[r] = m2[i0] ^ m2[i1] ^ col_in[i1] ^ col_in[i2] ^ col_in[i3];
            end else begin
                col_out[r] = (m8[i0] ^ m4[i0] ^ m2[i0])
                           ^ (m8[i1] ^ m2[i1] ^ col_in[i1])
                           ^ (m8[i2] ^ m4[i2] ^ col_in[i2])
                           ^ (m8[i3] ^ col_in[i3]);
            end
        end
    end

endmodule

// File: rtl/aes_mixcol_iter.sv
// Iterative column-mixing engine: accepts a state, mixes COLS columns per cycle in place,
// then holds the result under valid/ready backpressure.
//   state | meaning
//   IDLE  | waiting for an input state
//   BUSY  | mixing column group col_idx
//   DONE  | result on State_out, waiting for out_ready
module aes_mixcol_iter
    import aes_const::*;
    import aes_wire::*;
#(
    parameter int COLS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       mode,
    input  logic [7:0] State_in  [0:4*Nb-1],
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] State_out [0:4*Nb-1]
);

    localparam int IW = $clog2(Nb) + 1;
    localparam logic [IW-1:0] LAST = IW'(Nb - COLS);

    if (!(COLS == 1 || COLS == 2 || COLS == 4) || (Nb % COLS) != 0) begin : g_bad_cols
        $error("aes_mixcol_iter: COLS must be 1, 2 or 4 and divide Nb");
    end

    mixcol_fsm_t     fsm_q, fsm_d;
    logic [IW-1:0]   col_idx_q, col_idx_d;
    logic            mode_q, mode_d;
    logic [7:0]      state_q [0:4*Nb-1];
    logic [7:0]      state_d [0:4*Nb-1];
    logic            accept;
    col_t            col_sel [COLS];
    col_t            col_mix [COLS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q     <= IDLE;
            col_idx_q <= '0;
            mode_q    <= MIX_FWD;
            for (int i = 0; i < 4*Nb; i++) state_q[i] <= '0;
        end else begin
            fsm_q     <= fsm_d;
            col_idx_q <= col_idx_d;
            mode_q    <= mode_d;
            for (int i = 0; i < 4*Nb; i++) state_q[i] <= state_d[i];
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (accept) fsm_d = BUSY;
            BUSY:    if (col_idx_q == LAST) fsm_d = DONE;
            DONE:    if (out_ready) fsm_d = accept ? BUSY : IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // in_ready is held low while reset is asserted so nothing is taken on that edge.
    always_comb begin
        in_ready  = rst && ((fsm_q == IDLE) || (fsm_q == DONE && out_ready));
        out_valid = (fsm_q == DONE);
        accept    = in_valid && in_ready;
    end

    always_comb begin
        for (int g = 0; g < COLS; g++) begin
            col_sel[g] = '0;
            for (int c = 0; c < Nb; c++) begin
                if (col_idx_q + IW'(g) == IW'(c)) begin
                    for (int r = 0; r < 4; r++) col_sel[g][r] = state_q[4*c + r];
                end
            end
        end
    end

    for (genvar g = 0; g < COLS; g++) begin : g_unit
        aes_mixcol_unit u_mix (
            .col_in  (col_sel[g]),
            .mode    (mode_q),
            .col_out (col_mix[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        mode_d    = mode_q;
        if (accept) begin
            state_d   = State_in;
            col_idx_d = '0;
            mode_d    = mode;
        end else if (fsm_q == BUSY) begin
            col_idx_d = col_idx_q + IW'(COLS);
            for (int g = 0; g < COLS; g++) begin
                for (int c = 0; c < Nb; c++) begin
                    if (col_idx_q + IW'(g) == IW'(c)) begin
                        for (int r = 0; r < 4; r++) state_d[4*c + r] = col_mix[g][r];
                    end
                end
            end
        end
    end

    assign State_out = state_q;

endmodule

// File: tb/tb_aes_mixcol_iter.sv
// Bench for aes_mixcol_iter: one instance per COLS value (1, 2, 4), known-answer table,
// handshake corner cases and a randomized regression against a GF(2^8) reference model.
module tb_aes_mixcol_iter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_valid, in_ready, mode, out_valid, out_ready;
    logic [7:0] st_in  [3][16];
    logic [7:0] st_out [3][16];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int C = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        aes_mixcol_iter #(.COLS(C)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .mode      (mode[g]),
            .State_in  (st_in[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .State_out (st_out[g])
        );
    end

    typedef struct {
        logic [127:0] din;
        logic         md;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [4];

    function automatic int cols_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    // Generic shift-and-add GF(2^8) multiply, reduction polynomial 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] v, input logic md);
        logic [7:0] coef [4];
        logic [7:0] a [16];
        logic [127:0] res = '0;
        if (md) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int i = 0; i < 16; i++) a[i] = v[127-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                logic [7:0] o = 8'h00;
                for (int j = 0; j < 4; j++) o ^= gmul(coef[j], a[4*c + (r+j)%4]);
                res[127-8*(4*c+r) -: 8] = o;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] get_out(input int k);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = st_out[k][i];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_in(input int k, input logic [127:0] v);
        for (int i = 0; i < 16; i++) st_in[k][i] = v[127-8*i -: 8];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Full transaction on instance k with out_ready held high; returns result and latency.
    task automatic run_op(input int k, input logic [127:0] v, input logic md,
                          output logic [127:0] res, output int lat);
        set_in(k, v);
        mode[k]      = md;
        in_valid[k]  = 1'b1;
        out_ready[k] = 1'b1;
        chk("in_ready_idle", 128'(in_ready[k]), 128'd1);
        step();
        in_valid[k] = 1'b0;
        mode[k]     = ~md;
        set_in(k, rand128());
        lat = 0;
        while (!out_valid[k] && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 128'(lat), 128'(4 / cols_of(k)));
        res = get_out(k);
        step();
        chk("out_valid_after_xfer", 128'(out_valid[k]), 128'd0);
    endtask

    initial begin
        logic [127:0] r1, r2, v, exp;
        logic         md;
        int           lat;

        tbl[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                   128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        tbl[1] = '{128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1,
                   128'hdb135345_f20a225c_d4d4d4d5_2d26314c};
        tbl[2] = '{128'h0, 1'b0, 128'h0};
        tbl[3] = '{128'h0, 1'b1, 128'h0};

        rst       = 1'b0;
        in_valid  = '0;
        mode      = '0;
        out_ready = '1;
        for (int k = 0; k < 3; k++) set_in(k, 128'h0);
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            chk("reset_out_valid", 128'(out_valid[k]), 128'd0);
            chk("reset_in_ready", 128'(in_ready[k]), 128'd0);
            chk("reset_state_out", get_out(k), 128'h0);
        end
        rst = 1'b1;
        #1;

        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 3; k++) begin
                run_op(k, tbl[t].din, tbl[t].md, r1, lat);
                chk("table_vector", r1, tbl[t].exp);
            end
        end

        // Back-to-back on COLS=4: new accept on the DONE transfer edge.
        set_in(2, 128'h0);
        mode[2]     = 1'b0;
        in_valid[2] = 1'b1;
        step();
        set_in(2, tbl[1].din);
        mode[2] = 1'b1;
        chk("b2b_busy_not_ready", 128'(in_ready[2]), 128'd0);
        step();
        chk("b2b_first_valid", 128'(out_valid[2]), 128'd1);
        chk("b2b_first_result", get_out(2), 128'h0);
        chk("b2b_in_ready_done", 128'(in_ready[2]), 128'd1);
        step();
        in_valid[2] = 1'b0;
        chk("b2b_gap_valid_low", 128'(out_valid[2]), 128'd0);
        step();
        chk("b2b_second_valid", 128'(out_valid[2]), 128'd1);
        chk("b2b_second_result", get_out(2), tbl[1].exp);
        step();
        chk("b2b_back_idle", 128'(out_valid[2]), 128'd0);
        chk("b2b_idle_ready", 128'(in_ready[2]), 128'd1);

        // Backpressure on COLS=1.
        v  = rand128();
        md = 1'($urandom_range(0, 1));
        exp = mix_ref(v, md);
        set_in(0, v);
        mode[0]      = md;
        in_valid[0]  = 1'b1;
        step();
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 20) begin
            step();
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_state_stable", get_out(0), exp);
            chk("bp_in_ready_low", 128'(in_ready[0]), 128'd0);
            chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
            in_valid[0] = 1'($urandom_range(0, 1));
            mode[0]     = 1'($urandom_range(0, 1));
            set_in(0, rand128());
            step();
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        chk("bp_final_state", get_out(0), exp);
        step();
        chk("bp_xfer_valid_low", 128'(out_valid[0]), 128'd0);
        chk("bp_xfer_idle_ready", 128'(in_ready[0]), 128'd1);

        // Reset in the middle of BUSY on COLS=1.
        set_in(0, tbl[0].din);
        mode[0]     = 1'b0;
        in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("midrst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("midrst_state_zero", get_out(0), 128'h0);
        chk("midrst_in_ready", 128'(in_ready[0]), 128'd0);
        rst = 1'b1;
        #1;
        chk("midrst_idle_ready", 128'(in_ready[0]), 128'd1);
        step();
        chk("midrst_no_valid", 128'(out_valid[0]), 128'd0);
        run_op(0, tbl[0].din, 1'b0, r1, lat);
        chk("midrst_recover", r1, tbl[0].exp);

        // Random regression with round trip.
        for (int k = 0; k < 3; k++) begin
            for (int it = 0; it < 1000; it++) begin
                v  = rand128();
                md = 1'($urandom_range(0, 1));
                run_op(k, v, md, r1, lat);
                chk("rand_vs_model", r1, mix_ref(v, md));
                run_op(k, r1, ~md, r2, lat);
                chk("rand_round_trip", r2, v);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
